// File: rtl/demux_tree_buffered_pkg.sv
// Shared types, default widths and helpers for the buffered demux tree.
// The record layout documents what a 96-bit lane payload carries.
package demux_pkg;

    localparam int DATA_WIDTH_DEFAULT = 96;
    localparam int NUM_PORTS_DEFAULT  = 128;

    typedef struct packed {
        logic [31:0] pos_x;
        logic [31:0] pos_y;
        logic [31:0] pos_z;
    } record_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_tree_buffered_if.sv
// Input record channel, per-lane output channels and drop status of the demux tree.
// master drives records and lane ready; slave is the demux itself.
interface demux_tree_buffered_if
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH       = DATA_WIDTH_DEFAULT,
    parameter int NUM_OUTPUT_PORTS = NUM_PORTS_DEFAULT,
    parameter int SEL_WIDTH        = 7,
    parameter int DROP_CNT_WIDTH   = 16
);

    logic [DATA_WIDTH-1:0]                  in_data;
    logic [SEL_WIDTH-1:0]                   in_sel;
    logic                                   in_valid;
    logic                                   in_ready;
    logic [NUM_OUTPUT_PORTS*DATA_WIDTH-1:0] out_data;
    logic [NUM_OUTPUT_PORTS-1:0]            out_valid;
    logic [NUM_OUTPUT_PORTS-1:0]            out_ready;
    logic                                   drop_pulse;
    logic [DROP_CNT_WIDTH-1:0]              drop_cnt;

    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  drop_pulse,
        input  drop_cnt
    );

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output drop_pulse,
        output drop_cnt
    );

endinterface

// File: rtl/demux_tree_buffered_port_fifo.sv
// Per-lane FIFO with wrap-bit pointers; a write into a full FIFO is accepted
// only when a read frees a slot in the same cycle.
module demux_port_fifo
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty
);

    localparam int AW = clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/demux_tree_buffered.sv
// Steers one record per cycle through stage register S1 into per-lane FIFOs;
// out-of-range selects are discarded and counted instead of stalling the input.
module demux_tree_buffered
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH       = DATA_WIDTH_DEFAULT,
    parameter int NUM_OUTPUT_PORTS = NUM_PORTS_DEFAULT,
    parameter int SEL_WIDTH        = 7,
    parameter int FIFO_DEPTH       = 4,
    parameter int DROP_CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    demux_tree_buffered_if.slave  bus
);

    logic                  ready_en;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [SEL_WIDTH-1:0]  s1_sel;

    logic [NUM_OUTPUT_PORTS-1:0] sel_hit;
    logic [NUM_OUTPUT_PORTS-1:0] lane_blocked;
    logic [NUM_OUTPUT_PORTS-1:0] fifo_wr;
    logic [NUM_OUTPUT_PORTS-1:0] fifo_rd;
    logic [NUM_OUTPUT_PORTS-1:0] fifo_full;
    logic [NUM_OUTPUT_PORTS-1:0] fifo_empty;
    logic [DATA_WIDTH-1:0]       fifo_rd_data [NUM_OUTPUT_PORTS];

    logic in_range;
    logic s1_drain;
    logic drop;
    logic accept;

    for (genvar i = 0; i < NUM_OUTPUT_PORTS; i++) begin : g_lane
        assign sel_hit[i]      = (s1_sel == SEL_WIDTH'(i));
        // A full lane still takes a write when its consumer pops in the same cycle.
        assign lane_blocked[i] = fifo_full[i] && !bus.out_ready[i];
        assign fifo_wr[i]      = s1_valid && sel_hit[i] && !lane_blocked[i];
        assign fifo_rd[i]      = !fifo_empty[i] && bus.out_ready[i];

        demux_port_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (fifo_wr[i]),
            .wr_data (s1_data),
            .full    (fifo_full[i]),
            .rd_en   (fifo_rd[i]),
            .rd_data (fifo_rd_data[i]),
            .empty   (fifo_empty[i])
        );

        assign bus.out_valid[i]                          = !fifo_empty[i];
        assign bus.out_data[i*DATA_WIDTH +: DATA_WIDTH] = fifo_empty[i] ? '0 : fifo_rd_data[i];
    end

    assign in_range       = |sel_hit;
    assign drop           = s1_valid && !in_range;
    assign s1_drain       = s1_valid && (!in_range || |(sel_hit & ~lane_blocked));
    assign bus.in_ready   = ready_en && (!s1_valid || s1_drain);
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.drop_pulse = drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en     <= 1'b0;
            s1_valid     <= 1'b0;
            s1_data      <= '0;
            s1_sel       <= '0;
            bus.drop_cnt <= '0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= bus.in_data;
                s1_sel   <= bus.in_sel;
            end else if (s1_drain) begin
                s1_valid <= 1'b0;
            end
            if (drop && (bus.drop_cnt != '1)) begin
                bus.drop_cnt <= bus.drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_tree_buffered.sv
// Directed bench: a 128-lane instance for steering/backpressure/reset and a
// 100-lane, 2-bit-counter instance for out-of-range drops and saturation.
module tb_demux_tree_buffered;

    localparam int DW = 96;
    localparam int NA = 128;
    localparam int NB = 100;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    demux_tree_buffered_if #(.DATA_WIDTH(DW), .NUM_OUTPUT_PORTS(NA), .SEL_WIDTH(7), .DROP_CNT_WIDTH(16)) bus_a ();
    demux_tree_buffered_if #(.DATA_WIDTH(DW), .NUM_OUTPUT_PORTS(NB), .SEL_WIDTH(7), .DROP_CNT_WIDTH(2))  bus_b ();

    demux_tree_buffered #(
        .DATA_WIDTH(DW), .NUM_OUTPUT_PORTS(NA), .SEL_WIDTH(7), .FIFO_DEPTH(4), .DROP_CNT_WIDTH(16)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    demux_tree_buffered #(
        .DATA_WIDTH(DW), .NUM_OUTPUT_PORTS(NB), .SEL_WIDTH(7), .FIFO_DEPTH(4), .DROP_CNT_WIDTH(2)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] d_rec(input int k, input int tag);
        return {tag[31:0], k[31:0], 32'hA5A5_0000 | k[31:0]};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", bus_a.in_ready); end
        checks++;
        if (bus_a.out_valid !== '0) begin failures++; $display("FAIL reset_out_valid got=%h exp=0", bus_a.out_valid); end
        checks++;
        if (bus_a.out_data !== '0) begin failures++; $display("FAIL reset_out_data got=nonzero exp=0"); end
        checks++;
        if (bus_b.drop_cnt !== 2'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", bus_b.drop_cnt); end
        checks++;
        if (bus_b.drop_pulse !== 1'b0) begin failures++; $display("FAIL reset_drop_pulse got=%0b exp=0", bus_b.drop_pulse); end
        rst = 1'b1;
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b0) begin failures++; $display("FAIL release_in_ready_early got=%0b exp=0", bus_a.in_ready); end
        step();
        checks++;
        if (bus_a.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%0b exp=1", bus_a.in_ready); end
        checks++;
        if (bus_b.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready_b got=%0b exp=1", bus_b.in_ready); end
    endtask

    task automatic test_single;
        logic [NA*DW-1:0] exp_d;
        logic [NA-1:0]    exp_v;
        exp_d = '0;
        exp_d[5*DW +: DW] = 96'hA;
        exp_v = '0;
        exp_v[5] = 1'b1;
        bus_a.in_sel   = 7'd5;
        bus_a.in_data  = 96'hA;
        bus_a.in_valid = 1'b1;
        step();
        bus_a.in_valid = 1'b0;
        checks++;
        if (bus_a.out_valid !== '0) begin failures++; $display("FAIL single_t1_valid got=%h exp=0", bus_a.out_valid); end
        step();
        checks++;
        if (bus_a.out_valid !== exp_v) begin failures++; $display("FAIL single_t2_valid got=%h exp=%h", bus_a.out_valid, exp_v); end
        checks++;
        if (bus_a.out_data !== exp_d) begin failures++; $display("FAIL single_t2_data lane5=%h exp=%h", bus_a.out_data[5*DW +: DW], 96'hA); end
        step();
        checks++;
        if (bus_a.out_valid !== '0) begin failures++; $display("FAIL single_t3_valid got=%h exp=0", bus_a.out_valid); end
        checks++;
        if (bus_a.out_data !== '0) begin failures++; $display("FAIL single_t3_data got=nonzero exp=0"); end
    endtask

    task automatic test_back_to_back;
        logic [NA-1:0] exp_v;
        for (int c = 0; c <= NA + 1; c++) begin
            if (c < NA) begin
                bus_a.in_sel   = 7'(c);
                bus_a.in_data  = d_rec(c, 2);
                bus_a.in_valid = 1'b1;
                checks++;
                if (bus_a.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready c=%0d got=%0b exp=1", c, bus_a.in_ready); end
            end else begin
                bus_a.in_valid = 1'b0;
            end
            step();
            exp_v = '0;
            if (c >= 1 && c <= NA) exp_v[c-1] = 1'b1;
            checks++;
            if (bus_a.out_valid !== exp_v) begin failures++; $display("FAIL b2b_valid c=%0d got=%h exp=%h", c, bus_a.out_valid, exp_v); end
            if (c >= 1 && c <= NA) begin
                checks++;
                if (bus_a.out_data[(c-1)*DW +: DW] !== d_rec(c - 1, 2)) begin
                    failures++;
                    $display("FAIL b2b_data lane=%0d got=%h exp=%h", c - 1, bus_a.out_data[(c-1)*DW +: DW], d_rec(c - 1, 2));
                end
            end
        end
        checks++;
        if (bus_a.drop_cnt !== 16'd0) begin failures++; $display("FAIL b2b_drop_cnt got=%0d exp=0", bus_a.drop_cnt); end
    endtask

    task automatic test_lane_stall;
        int   rx;
        logic acc;
        bus_a.out_ready    = '1;
        bus_a.out_ready[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_a.in_sel   = 7'd3;
            bus_a.in_data  = d_rec(i, 3);
            bus_a.in_valid = 1'b1;
            checks++;
            if (bus_a.in_ready !== 1'b1) begin failures++; $display("FAIL stall_fill_ready i=%0d got=%0b exp=1", i, bus_a.in_ready); end
            step();
        end
        bus_a.in_data = d_rec(5, 3);
        checks++;
        if (bus_a.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%0b exp=0", bus_a.in_ready); end
        checks++;
        if (bus_a.out_valid[3] !== 1'b1) begin failures++; $display("FAIL stall_valid3 got=%0b exp=1", bus_a.out_valid[3]); end
        checks++;
        if (bus_a.out_data[3*DW +: DW] !== d_rec(0, 3)) begin failures++; $display("FAIL stall_head got=%h exp=%h", bus_a.out_data[3*DW +: DW], d_rec(0, 3)); end
        repeat (2) step();
        checks++;
        if (bus_a.in_ready !== 1'b0) begin failures++; $display("FAIL stall_hold_ready got=%0b exp=0", bus_a.in_ready); end
        bus_a.out_ready[3] = 1'b1;
        #1;
        rx = 0;
        for (int n = 0; n < 40 && rx < 6; n++) begin
            if (bus_a.out_valid[3]) begin
                checks++;
                if (bus_a.out_data[3*DW +: DW] !== d_rec(rx, 3)) begin
                    failures++;
                    $display("FAIL stall_order idx=%0d got=%h exp=%h", rx, bus_a.out_data[3*DW +: DW], d_rec(rx, 3));
                end
                rx++;
            end
            acc = bus_a.in_valid && bus_a.in_ready;
            step();
            if (acc) bus_a.in_valid = 1'b0;
        end
        checks++;
        if (rx != 6) begin failures++; $display("FAIL stall_count got=%0d exp=6", rx); end
        checks++;
        if (bus_a.in_ready !== 1'b1) begin failures++; $display("FAIL stall_recover_ready got=%0b exp=1", bus_a.in_ready); end
    endtask

    task automatic test_head_of_line;
        int   pops3;
        int   pops_before;
        logic seen7;
        logic acc;
        bus_a.out_ready    = '1;
        bus_a.out_ready[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_a.in_sel   = 7'd3;
            bus_a.in_data  = d_rec(i, 4);
            bus_a.in_valid = 1'b1;
            step();
        end
        bus_a.in_sel  = 7'd7;
        bus_a.in_data = d_rec(77, 4);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus_a.in_ready !== 1'b0) begin failures++; $display("FAIL hol_in_ready i=%0d got=%0b exp=0", i, bus_a.in_ready); end
            checks++;
            if (bus_a.out_valid[7] !== 1'b0) begin failures++; $display("FAIL hol_valid7_early i=%0d got=%0b exp=0", i, bus_a.out_valid[7]); end
            step();
        end
        bus_a.out_ready[3] = 1'b1;
        #1;
        pops3 = 0;
        pops_before = 0;
        seen7 = 1'b0;
        for (int n = 0; n < 40 && !(seen7 && pops3 == 5); n++) begin
            if (bus_a.out_valid[3]) begin
                checks++;
                if (bus_a.out_data[3*DW +: DW] !== d_rec(pops3, 4)) begin
                    failures++;
                    $display("FAIL hol_lane3_order idx=%0d got=%h exp=%h", pops3, bus_a.out_data[3*DW +: DW], d_rec(pops3, 4));
                end
                pops3++;
            end
            if (bus_a.out_valid[7] && !seen7) begin
                seen7 = 1'b1;
                pops_before = pops3;
                checks++;
                if (bus_a.out_data[7*DW +: DW] !== d_rec(77, 4)) begin
                    failures++;
                    $display("FAIL hol_lane7_data got=%h exp=%h", bus_a.out_data[7*DW +: DW], d_rec(77, 4));
                end
            end
            acc = bus_a.in_valid && bus_a.in_ready;
            step();
            if (acc) bus_a.in_valid = 1'b0;
        end
        checks++;
        if (seen7 !== 1'b1) begin failures++; $display("FAIL hol_lane7_seen got=%0b exp=1", seen7); end
        checks++;
        if (pops3 != 5) begin failures++; $display("FAIL hol_lane3_count got=%0d exp=5", pops3); end
        checks++;
        if (pops_before < 1) begin failures++; $display("FAIL hol_lane7_after_lane3 pops_before=%0d exp>=1", pops_before); end
    endtask

    task automatic test_drops;
        int            pulses;
        int            sels[4];
        logic [NB-1:0] exp_v;
        sels = '{100, 127, 101, 110};
        bus_b.out_ready = '1;
        bus_b.in_sel    = 7'd120;
        bus_b.in_data   = d_rec(120, 5);
        bus_b.in_valid  = 1'b1;
        step();
        bus_b.in_valid = 1'b0;
        checks++;
        if (bus_b.drop_pulse !== 1'b1) begin failures++; $display("FAIL drop_pulse_hi got=%0b exp=1", bus_b.drop_pulse); end
        checks++;
        if (bus_b.drop_cnt !== 2'd0) begin failures++; $display("FAIL drop_cnt_pre got=%0d exp=0", bus_b.drop_cnt); end
        checks++;
        if (bus_b.out_valid !== '0) begin failures++; $display("FAIL drop_valid_t1 got=%h exp=0", bus_b.out_valid); end
        step();
        checks++;
        if (bus_b.drop_pulse !== 1'b0) begin failures++; $display("FAIL drop_pulse_lo got=%0b exp=0", bus_b.drop_pulse); end
        checks++;
        if (bus_b.drop_cnt !== 2'd1) begin failures++; $display("FAIL drop_cnt_one got=%0d exp=1", bus_b.drop_cnt); end
        checks++;
        if (bus_b.out_valid !== '0) begin failures++; $display("FAIL drop_valid_t2 got=%h exp=0", bus_b.out_valid); end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            bus_b.in_sel   = 7'(sels[i]);
            bus_b.in_data  = d_rec(sels[i], 5);
            bus_b.in_valid = 1'b1;
            checks++;
            if (bus_b.in_ready !== 1'b1) begin failures++; $display("FAIL drop_b2b_ready i=%0d got=%0b exp=1", i, bus_b.in_ready); end
            step();
            if (bus_b.drop_pulse) pulses++;
        end
        bus_b.in_valid = 1'b0;
        step();
        if (bus_b.drop_pulse) pulses++;
        checks++;
        if (pulses != 4) begin failures++; $display("FAIL drop_pulse_count got=%0d exp=4", pulses); end
        checks++;
        if (bus_b.drop_cnt !== 2'd3) begin failures++; $display("FAIL drop_cnt_sat got=%0d exp=3", bus_b.drop_cnt); end
        checks++;
        if (bus_b.out_valid !== '0) begin failures++; $display("FAIL drop_valid_after got=%h exp=0", bus_b.out_valid); end
        bus_b.in_sel   = 7'd99;
        bus_b.in_data  = d_rec(99, 5);
        bus_b.in_valid = 1'b1;
        step();
        bus_b.in_valid = 1'b0;
        step();
        exp_v = '0;
        exp_v[99] = 1'b1;
        checks++;
        if (bus_b.out_valid !== exp_v) begin failures++; $display("FAIL top_lane_valid got=%h exp=%h", bus_b.out_valid, exp_v); end
        checks++;
        if (bus_b.out_data[99*DW +: DW] !== d_rec(99, 5)) begin failures++; $display("FAIL top_lane_data got=%h exp=%h", bus_b.out_data[99*DW +: DW], d_rec(99, 5)); end
        checks++;
        if (bus_b.drop_cnt !== 2'd3) begin failures++; $display("FAIL top_lane_drop_cnt got=%0d exp=3", bus_b.drop_cnt); end
        step();
    endtask

    task automatic test_mid_reset;
        int            sels[4];
        logic [NA-1:0] exp_v;
        sels = '{1, 2, 2, 9};
        bus_a.out_ready = '0;
        for (int i = 0; i < 4; i++) begin
            bus_a.in_sel   = 7'(sels[i]);
            bus_a.in_data  = d_rec(i, 6);
            bus_a.in_valid = 1'b1;
            step();
        end
        bus_a.in_valid = 1'b0;
        repeat (2) step();
        exp_v = '0;
        exp_v[1] = 1'b1;
        exp_v[2] = 1'b1;
        exp_v[9] = 1'b1;
        checks++;
        if (bus_a.out_valid !== exp_v) begin failures++; $display("FAIL mid_pre_valid got=%h exp=%h", bus_a.out_valid, exp_v); end
        checks++;
        if (bus_a.out_data[2*DW +: DW] !== d_rec(1, 6)) begin failures++; $display("FAIL mid_pre_lane2 got=%h exp=%h", bus_a.out_data[2*DW +: DW], d_rec(1, 6)); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus_a.out_valid !== '0) begin failures++; $display("FAIL mid_rst_valid got=%h exp=0", bus_a.out_valid); end
        checks++;
        if (bus_a.out_data !== '0) begin failures++; $display("FAIL mid_rst_data got=nonzero exp=0"); end
        checks++;
        if (bus_a.in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_in_ready got=%0b exp=0", bus_a.in_ready); end
        checks++;
        if (bus_b.drop_cnt !== 2'd0) begin failures++; $display("FAIL mid_rst_drop_cnt got=%0d exp=0", bus_b.drop_cnt); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus_a.out_ready = '1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus_a.out_valid !== '0) begin failures++; $display("FAIL mid_stale_valid i=%0d got=%h exp=0", i, bus_a.out_valid); end
        end
        checks++;
        if (bus_a.in_ready !== 1'b1) begin failures++; $display("FAIL mid_post_in_ready got=%0b exp=1", bus_a.in_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        bus_a.in_data   = '0;
        bus_a.in_sel    = '0;
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = '1;
        bus_b.in_data   = '0;
        bus_b.in_sel    = '0;
        bus_b.in_valid  = 1'b0;
        bus_b.out_ready = '1;

        test_reset();
        test_single();
        test_back_to_back();
        test_lane_stall();
        test_head_of_line();
        test_drops();
        test_mid_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
